// File: rtl/alu_serial_ctrl.sv
// Bit-serial controller for an external 1-bit ALU element. It feeds one operand bit pair per
// cycle, LSB first, and builds the result word from the returned bits with the carry rippled through.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             alu_x,
  output logic             alu_y,
  output logic             alu_w,
  output logic             alu_ci,
  output logic             alu_a,
  output logic             alu_b,
  input  logic             alu_co,
  input  logic             alu_s,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a_shift;
  logic [WIDTH-1:0] r_b_shift;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_a_shift <= '0;
      r_b_shift <= '0;
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op      <= op;
            r_a_shift <= a_in;
            r_b_shift <= b_in;
            r_carry   <= cin;
            r_cnt     <= '0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_a_shift <= r_a_shift >> 1;
          r_b_shift <= r_b_shift >> 1;
          r_result  <= {alu_s, r_result[WIDTH-1:1]};
          r_carry   <= alu_co;
          // Counter parks on the last bit index rather than wrapping.
          if (r_cnt == LAST_BIT) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_run  = (r_state == S_RUN);
  assign alu_x  = w_run & r_op[2];
  assign alu_y  = w_run & r_op[1];
  assign alu_w  = w_run & r_op[0];
  assign alu_ci = w_run & r_carry;
  assign alu_a  = w_run & r_a_shift[0];
  assign alu_b  = w_run & r_b_shift[0];

  assign busy   = w_run;
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign cout   = r_carry;
  assign zero   = (r_result == '0);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl with a full adder as the ALU element. Results are checked
// against whole-word arithmetic: a + b + cin.
module tb_alu_serial_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic             cin;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             alu_x, alu_y, alu_w, alu_ci, alu_a, alu_b;
  logic             alu_co, alu_s;
  logic             busy, done, cout, zero;
  logic [WIDTH-1:0] result;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // Full-adder model of the external 1-bit element.
  assign alu_s  = alu_a ^ alu_b ^ alu_ci;
  assign alu_co = (alu_a & alu_b) | (alu_a & alu_ci) | (alu_b & alu_ci);

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .cin(cin),
    .a_in(a_in), .b_in(b_in),
    .alu_x(alu_x), .alu_y(alu_y), .alu_w(alu_w),
    .alu_ci(alu_ci), .alu_a(alu_a), .alu_b(alu_b),
    .alu_co(alu_co), .alu_s(alu_s),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble;
    a_in = WIDTH'($urandom);
    b_in = WIDTH'($urandom);
    cin  = 1'($urandom);
    op   = 3'($urandom);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic [2:0] o,
                        input bit pulse_run, input bit pulse_done);
    int n;
    int carry_in_n;
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(ci);
    a_in = a; b_in = b; cin = ci; op = o; start = 1'b1;
    tick;
    start = 1'b0;
    scramble;
    n = 0;
    while (!done && n < 3 * WIDTH) begin
      if (n < WIDTH) begin
        carry_in_n = ((int'(a) % (1 << n)) + (int'(b) % (1 << n)) + int'(ci)) >> n;
        check("busy_run", busy, 1);
        check("alu_op", {alu_x, alu_y, alu_w}, o);
        check("alu_a", alu_a, a[n]);
        check("alu_b", alu_b, b[n]);
        check("alu_ci", alu_ci, carry_in_n & 1);
      end
      if (pulse_run && n == 3) begin
        scramble;
        start = 1'b1;
      end
      tick;
      start = 1'b0;
      n++;
    end
    check("latency", n, WIDTH);
    check("done", done, 1);
    check("busy_done", busy, 0);
    check("result", result, sum[WIDTH-1:0]);
    check("cout", cout, sum[WIDTH]);
    check("zero", zero, (sum[WIDTH-1:0] == 0) ? 1 : 0);
    check("alu_idle_in_done", {alu_x, alu_y, alu_w, alu_ci, alu_a, alu_b}, 0);
    if (pulse_done) begin
      scramble;
      start = 1'b1;
    end
    tick;
    start = 1'b0;
    $display("[TB] op a=%02h b=%02h cin=%0d -> result=%02h cout=%0d zero=%0d",
             a, b, ci, result, cout, zero);
    check("done_one_cycle", done, 0);
    check("busy_after", busy, 0);
    check("result_hold", result, sum[WIDTH-1:0]);
    check("cout_hold", cout, sum[WIDTH]);
  endtask

  initial begin
    bit saw_done;
    reset = 1'b1; start = 1'b0; op = '0; cin = 1'b0; a_in = '0; b_in = '0;
    tick;
    tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_zero", zero, 1);
    check("rst_alu", {alu_x, alu_y, alu_w, alu_ci, alu_a, alu_b}, 0);
    reset = 1'b0;
    tick;

    run_op(8'h5A, 8'h3C, 1'b0, 3'b011, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 3'b110, 1'b0, 1'b0);
    run_op(8'h10, 8'hFC, 1'b1, 3'b101, 1'b0, 1'b0);
    run_op(8'h12, 8'h34, 1'b0, 3'b001, 1'b1, 1'b1);

    // Idle with start low: nothing moves.
    scramble;
    for (int i = 0; i < 3; i++) tick;
    check("idle_busy", busy, 0);
    check("idle_result", result, 8'h46);

    // Reset lands on the 4th RUN edge.
    a_in = 8'h77; b_in = 8'h22; cin = 1'b0; op = 3'b010; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_cout", cout, 0);
    check("midrst_zero", zero, 1);
    saw_done = 1'b0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (done || busy) saw_done = 1'b1;
      tick;
    end
    check("midrst_no_done", saw_done, 0);
    run_op(8'h01, 8'h01, 1'b0, 3'b000, 1'b0, 1'b0);

    // Random back-to-back operations with stray start pulses.
    for (int k = 0; k < 12; k++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 3'($urandom),
             1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
